// File: rtl/sdc_traffic_gen.sv
// SDRAM-controller traffic generator: writes a pattern over num_req bursts,
// reads them back, compares, and reports errors, timeout and completion.
module sdc_traffic_gen #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  mclk,
    input  logic                  s_resetn,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_adr,
    input  logic [ADDR_W-1:0]     stride,
    input  logic [CNT_W-1:0]      num_req,
    input  logic [1:0]            req_len,
    input  logic                  sdc_init_done,
    output logic                  sdc_req,
    output logic [ADDR_W-1:0]     sdc_req_adr,
    output logic [1:0]            sdc_req_len,
    output logic                  sdc_req_wr_n,
    input  logic                  sdc_req_ack,
    output logic [DATA_W-1:0]     sdc_wr_data,
    output logic [DATA_W/8-1:0]   sdc_wr_en_n,
    input  logic                  sdc_wr_next,
    input  logic [DATA_W-1:0]     sdc_rd_data,
    input  logic                  sdc_rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [ADDR_W-1:0]     first_err_adr
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned WK_W = 5;
    localparam int unsigned G_W  = CNT_W + WK_W;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_DATA = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [1:0]          cfg_mode;
    logic [ADDR_W-1:0]   cfg_base;
    logic [ADDR_W-1:0]   cfg_stride;
    logic [CNT_W-1:0]    cfg_num;
    logic [CNT_W-1:0]    req_idx;
    logic [WK_W-1:0]     word_idx;
    logic [G_W-1:0]      glob_idx;
    logic [WD_W-1:0]     wdog;

    logic                load_c;
    logic                active_c;
    logic                progress_c;
    logic                wd_expire_c;
    logic                req_acc_c;
    logic                wr_step_c;
    logic                rd_step_c;
    logic                last_word_c;
    logic                last_req_c;
    logic                mismatch_c;
    logic                overrun_c;
    logic [WK_W-1:0]     words_m1_c;
    logic [DATA_W-1:0]   pat_cur_c;
    logic [DATA_W-1:0]   pat_nxt_c;

    // Pattern word for global index g; ADDR mode uses the burst address plus word-in-burst.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                   input logic [G_W-1:0]    g,
                                                   input logic [ADDR_W-1:0] a,
                                                   input logic [WK_W-1:0]   k);
        logic [DATA_W-1:0] w;
        w = '0;
        case (m)
            2'b00:   w = DATA_W'(g);
            2'b01:   w = DATA_W'(1) << g[SH_W-1:0];
            2'b10:   w = g[0] ? {BE_W{8'h55}} : {BE_W{8'hAA}};
            default: w = DATA_W'(a) + DATA_W'(k);
        endcase
        return w;
    endfunction

    assign sdc_wr_en_n = '0;

    // State register.
    always_ff @(posedge mclk or negedge s_resetn) begin
        if (!s_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; watchdog expiry overrides everything else.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (load_c) state_nxt = WR_REQ;
            WR_REQ:     if (sdc_req_ack) state_nxt = WR_DATA;
            WR_DATA:    if (wr_step_c && last_word_c) state_nxt = last_req_c ? RD_REQ : WR_REQ;
            RD_REQ:     if (sdc_req_ack) state_nxt = RD_DATA;
            RD_DATA:    if (rd_step_c && last_word_c) state_nxt = last_req_c ? DONE : RD_REQ;
            default:    state_nxt = IDLE;
        endcase
        if (wd_expire_c) begin
            state_nxt = DONE;
        end
    end

    // Per-cycle control strobes consumed by the datapath.
    always_comb begin
        load_c      = 1'b0;
        active_c    = 1'b0;
        progress_c  = 1'b0;
        req_acc_c   = 1'b0;
        wr_step_c   = 1'b0;
        rd_step_c   = 1'b0;
        overrun_c   = 1'b0;
        words_m1_c  = WK_W'((32'd4 << sdc_req_len) - 32'd1);
        last_word_c = (word_idx == words_m1_c);
        last_req_c  = (req_idx == cfg_num - CNT_W'(1));
        pat_cur_c   = pattern(cfg_mode, glob_idx, sdc_req_adr, word_idx);
        pat_nxt_c   = pattern(cfg_mode, glob_idx + G_W'(1), sdc_req_adr, word_idx + WK_W'(1));
        case (state)
            IDLE, DONE: begin
                load_c = start && sdc_init_done && (num_req != '0);
            end
            WR_REQ, RD_REQ: begin
                active_c   = 1'b1;
                progress_c = sdc_req_ack;
                req_acc_c  = sdc_req_ack;
                overrun_c  = sdc_rd_valid;
            end
            WR_DATA: begin
                active_c   = 1'b1;
                progress_c = sdc_wr_next;
                wr_step_c  = sdc_wr_next;
                overrun_c  = sdc_rd_valid;
            end
            RD_DATA: begin
                active_c   = 1'b1;
                progress_c = sdc_rd_valid;
                rd_step_c  = sdc_rd_valid;
            end
            default: ;
        endcase
        mismatch_c  = rd_step_c && (sdc_rd_data != pat_cur_c);
        wd_expire_c = active_c && !progress_c && (wdog == WD_W'(TIMEOUT - 1));
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge mclk or negedge s_resetn) begin
        if (!s_resetn) begin
            sdc_req       <= 1'b0;
            sdc_req_adr   <= '0;
            sdc_req_len   <= '0;
            sdc_req_wr_n  <= 1'b0;
            sdc_wr_data   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            first_err_adr <= '0;
            cfg_mode      <= '0;
            cfg_base      <= '0;
            cfg_stride    <= '0;
            cfg_num       <= '0;
            req_idx       <= '0;
            word_idx      <= '0;
            glob_idx      <= '0;
            wdog          <= '0;
        end else begin
            sdc_req <= (state_nxt == WR_REQ) || (state_nxt == RD_REQ);
            busy    <= (state_nxt != IDLE) && (state_nxt != DONE);
            done    <= (state_nxt == DONE);
            if (load_c) begin
                cfg_mode      <= mode;
                cfg_base      <= base_adr;
                cfg_stride    <= stride;
                cfg_num       <= num_req;
                sdc_req_adr   <= base_adr;
                sdc_req_len   <= req_len;
                sdc_req_wr_n  <= 1'b0;
                req_idx       <= '0;
                word_idx      <= '0;
                glob_idx      <= '0;
                wdog          <= '0;
                timeout       <= 1'b0;
                err_cnt       <= '0;
                first_err_adr <= '0;
            end else begin
                wdog <= (active_c && !progress_c) ? wdog + WD_W'(1) : '0;
                if (wd_expire_c) begin
                    timeout <= 1'b1;
                end
                if (req_acc_c && (state == WR_REQ)) begin
                    sdc_wr_data <= pat_cur_c;
                end
                // Burst bookkeeping; read phase restarts addresses and pattern from the top.
                if (wr_step_c || rd_step_c) begin
                    if (last_word_c) begin
                        word_idx <= '0;
                        if (last_req_c) begin
                            req_idx      <= '0;
                            glob_idx     <= '0;
                            sdc_req_adr  <= cfg_base;
                            sdc_req_wr_n <= 1'b1;
                        end else begin
                            req_idx     <= req_idx + CNT_W'(1);
                            glob_idx    <= glob_idx + G_W'(1);
                            sdc_req_adr <= sdc_req_adr + cfg_stride;
                        end
                    end else begin
                        word_idx <= word_idx + WK_W'(1);
                        glob_idx <= glob_idx + G_W'(1);
                        if (wr_step_c) begin
                            sdc_wr_data <= pat_nxt_c;
                        end
                    end
                end
                if ((mismatch_c || overrun_c) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
                if (mismatch_c && (err_cnt == '0)) begin
                    first_err_adr <= sdc_req_adr;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdc_traffic_gen.sv
// Bench for sdc_traffic_gen: memory-model responder plus request/write-data scoreboard.
module tb_sdc_traffic_gen;

    logic        mclk = 1'b0;
    logic        s_resetn;
    logic        start;
    logic [1:0]  mode;
    logic [22:0] base_adr;
    logic [22:0] stride;
    logic [15:0] num_req;
    logic [1:0]  req_len;
    logic        sdc_init_done;
    logic        sdc_req;
    logic [22:0] sdc_req_adr;
    logic [1:0]  sdc_req_len;
    logic        sdc_req_wr_n;
    logic        sdc_req_ack;
    logic [31:0] sdc_wr_data;
    logic [3:0]  sdc_wr_en_n;
    logic        sdc_wr_next;
    logic [31:0] sdc_rd_data;
    logic        sdc_rd_valid;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] err_cnt;
    logic [22:0] first_err_adr;

    typedef struct packed {
        logic [22:0] adr;
        logic        wr_n;
        logic [1:0]  len;
    } req_t;

    req_t        req_q[$];
    logic [31:0] wdat_q[$];
    logic [31:0] mem[longint];

    int n_cmp = 0;
    int n_fail = 0;
    bit ack_en = 1'b1;
    int rd_req_cnt = 0;
    int wr_words = 0;
    int corrupt_req = -1;
    int corrupt_k = 0;

    always #5 mclk = ~mclk;

    sdc_traffic_gen #(
        .DATA_W(32), .ADDR_W(23), .CNT_W(16), .TIMEOUT(1024)
    ) dut (
        .mclk(mclk), .s_resetn(s_resetn), .start(start), .mode(mode),
        .base_adr(base_adr), .stride(stride), .num_req(num_req), .req_len(req_len),
        .sdc_init_done(sdc_init_done), .sdc_req(sdc_req), .sdc_req_adr(sdc_req_adr),
        .sdc_req_len(sdc_req_len), .sdc_req_wr_n(sdc_req_wr_n), .sdc_req_ack(sdc_req_ack),
        .sdc_wr_data(sdc_wr_data), .sdc_wr_en_n(sdc_wr_en_n), .sdc_wr_next(sdc_wr_next),
        .sdc_rd_data(sdc_rd_data), .sdc_rd_valid(sdc_rd_valid), .busy(busy), .done(done),
        .timeout(timeout), .err_cnt(err_cnt), .first_err_adr(first_err_adr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int m, input int g, input logic [22:0] a, input int k);
        logic [31:0] w;
        case (m)
            0:       w = 32'(g);
            1:       w = 32'h1 << (g % 32);
            2:       w = ((g % 2) == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
            default: w = {9'd0, a} + 32'(k);
        endcase
        return w;
    endfunction

    task automatic check_reset(input string pfx);
        check({pfx, "_req"},       64'(sdc_req),       64'd0);
        check({pfx, "_req_adr"},   64'(sdc_req_adr),   64'd0);
        check({pfx, "_req_len"},   64'(sdc_req_len),   64'd0);
        check({pfx, "_req_wr_n"},  64'(sdc_req_wr_n),  64'd0);
        check({pfx, "_wr_data"},   64'(sdc_wr_data),   64'd0);
        check({pfx, "_wr_en_n"},   64'(sdc_wr_en_n),   64'd0);
        check({pfx, "_busy"},      64'(busy),          64'd0);
        check({pfx, "_done"},      64'(done),          64'd0);
        check({pfx, "_timeout"},   64'(timeout),       64'd0);
        check({pfx, "_err_cnt"},   64'(err_cnt),       64'd0);
        check({pfx, "_first_err"}, 64'(first_err_adr), 64'd0);
    endtask

    task automatic pulse_start(input logic [22:0] base, input logic [22:0] strd,
                               input int num, input int len, input int m);
        @(negedge mclk);
        base_adr   = base;
        stride     = strd;
        num_req    = 16'(num);
        req_len    = 2'(len);
        mode       = 2'(m);
        rd_req_cnt = 0;
        wr_words   = 0;
        start      = 1'b1;
        @(negedge mclk);
        start      = 1'b0;
    endtask

    // Push the expected request stream and write words, then launch the run.
    task automatic queue_run(input logic [22:0] base, input logic [22:0] strd,
                             input int num, input int len, input int m);
        logic [22:0] a;
        int g;
        int words;
        words = 4 << len;
        a = base;
        g = 0;
        for (int i = 0; i < num; i++) begin
            req_q.push_back({a, 1'b0, 2'(len)});
            for (int k = 0; k < words; k++) begin
                wdat_q.push_back(exp_word(m, g, a, k));
                g++;
            end
            a = a + strd;
        end
        a = base;
        for (int i = 0; i < num; i++) begin
            req_q.push_back({a, 1'b1, 2'(len)});
            a = a + strd;
        end
        pulse_start(base, strd, num, len, m);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge mclk);
            #1;
            cyc++;
            if (done) break;
        end
        check("run_done", 64'(done), 64'd1);
    endtask

    task automatic check_clean_end(input string pfx);
        check({pfx, "_busy"},    64'(busy),          64'd0);
        check({pfx, "_err_cnt"}, 64'(err_cnt),       64'd0);
        check({pfx, "_timeout"}, 64'(timeout),       64'd0);
        check({pfx, "_req_q"},   64'(req_q.size()),  64'd0);
        check({pfx, "_wdat_q"},  64'(wdat_q.size()), 64'd0);
    endtask

    // Memory-model responder: acks requests, consumes write data, returns read data.
    initial begin : responder
        int phase;
        int k;
        int words;
        int rd_idx;
        logic [22:0] cur;
        req_t e;
        logic [31:0] d;
        phase = 0; k = 0; words = 0; rd_idx = 0; cur = '0;
        sdc_req_ack = 1'b0; sdc_wr_next = 1'b0; sdc_rd_valid = 1'b0; sdc_rd_data = '0;
        forever begin
            @(posedge mclk);
            #1;
            sdc_req_ack = 1'b0; sdc_wr_next = 1'b0; sdc_rd_valid = 1'b0;
            if (!s_resetn) begin
                phase = 0;
                continue;
            end
            case (phase)
                0: if (sdc_req && ack_en && ($urandom_range(0, 2) != 0)) begin
                    sdc_req_ack = 1'b1;
                    cur   = sdc_req_adr;
                    words = 4 << sdc_req_len;
                    k     = 0;
                    check("req_expected", 64'(req_q.size() != 0), 64'd1);
                    if (req_q.size() != 0) begin
                        e = req_q.pop_front();
                        check("req_adr",  64'(sdc_req_adr),  64'(e.adr));
                        check("req_wr_n", 64'(sdc_req_wr_n), 64'(e.wr_n));
                        check("req_len",  64'(sdc_req_len),  64'(e.len));
                    end
                    if (sdc_req_wr_n) begin
                        rd_idx = rd_req_cnt;
                        rd_req_cnt++;
                        phase = 2;
                    end else begin
                        phase = 1;
                    end
                end
                1: if ($urandom_range(0, 3) != 0) begin
                    sdc_wr_next = 1'b1;
                    check("wr_expected", 64'(wdat_q.size() != 0), 64'd1);
                    if (wdat_q.size() != 0) begin
                        check("wr_data", 64'(sdc_wr_data), 64'(wdat_q.pop_front()));
                    end
                    mem[longint'(cur) * 64 + k] = sdc_wr_data;
                    wr_words++;
                    k++;
                    if (k == words) phase = 0;
                end
                2: if ($urandom_range(0, 3) != 0) begin
                    d = mem.exists(longint'(cur) * 64 + k) ? mem[longint'(cur) * 64 + k] : 32'd0;
                    if (rd_idx == corrupt_req && k == corrupt_k) d = d ^ 32'h1;
                    sdc_rd_data  = d;
                    sdc_rd_valid = 1'b1;
                    k++;
                    if (k == words) phase = 0;
                end
                default: phase = 0;
            endcase
        end
    end

    initial begin : main
        int cyc;
        s_resetn = 1'b0; start = 1'b0; mode = '0; base_adr = '0; stride = '0;
        num_req = '0; req_len = '0; sdc_init_done = 1'b0;
        repeat (3) @(negedge mclk);
        check_reset("rst");
        s_resetn = 1'b1;

        // Starts that must be ignored: zero requests, then controller not initialised.
        sdc_init_done = 1'b1;
        pulse_start(23'h100, 23'h10, 0, 0, 0);
        @(posedge mclk); #1;
        check("ign_num0_busy", 64'(busy), 64'd0);
        sdc_init_done = 1'b0;
        pulse_start(23'h100, 23'h10, 2, 0, 0);
        @(posedge mclk); #1;
        check("ign_init_busy", 64'(busy), 64'd0);
        check("ign_init_req",  64'(sdc_req), 64'd0);
        sdc_init_done = 1'b1;

        queue_run(23'h000200, 23'h20, 2, 1, 0);
        @(posedge mclk); #1;
        check("inc_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check_clean_end("inc");

        queue_run(23'h001000, 23'h80, 2, 3, 1);
        wait_done(cyc);
        check_clean_end("walk1");

        queue_run(23'h002000, 23'h10, 3, 0, 2);
        wait_done(cyc);
        check_clean_end("alt");

        queue_run(23'h003000, 23'h40, 2, 2, 3);
        wait_done(cyc);
        check_clean_end("addr");

        // Corrupt read word 5 of request 1.
        corrupt_req = 1;
        corrupt_k   = 5;
        queue_run(23'h000400, 23'h40, 2, 1, 0);
        wait_done(cyc);
        check("corrupt_err_cnt",   64'(err_cnt),       64'd1);
        check("corrupt_first_err", 64'(first_err_adr), 64'h440);
        check("corrupt_req_q",     64'(req_q.size()),  64'd0);
        corrupt_req = -1;

        // Address wrap, plus a start while busy that must not disturb the run.
        queue_run(23'h7FFFE0, 23'h20, 2, 0, 0);
        repeat (5) @(negedge mclk);
        base_adr = 23'h123; num_req = 16'd5; start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        wait_done(cyc);
        check_clean_end("wrap");

        // No ack ever: watchdog must end the run.
        ack_en = 1'b0;
        pulse_start(23'h000800, 23'h20, 1, 0, 0);
        wait_done(cyc);
        check("wd_cycles",  64'(cyc),     64'd1024);
        check("wd_timeout", 64'(timeout), 64'd1);
        check("wd_req",     64'(sdc_req), 64'd0);
        check("wd_busy",    64'(busy),    64'd0);
        ack_en = 1'b1;

        // Reset in the middle of a write burst, then a clean run.
        queue_run(23'h000500, 23'h20, 2, 2, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge mclk);
            if (wr_words >= 3) break;
        end
        check("mid_wr_reached", 64'(wr_words >= 3), 64'd1);
        s_resetn = 1'b0;
        #1;
        check_reset("midrst");
        req_q.delete();
        wdat_q.delete();
        repeat (2) @(negedge mclk);
        s_resetn = 1'b1;
        @(posedge mclk); #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        queue_run(23'h000600, 23'h20, 1, 1, 3);
        wait_done(cyc);
        check_clean_end("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdc_traffic_gen.md
SDC_TRAFFIC_GEN -- requirements
Module: sdc_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, user data width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter ADDR_W, default 23, user address width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, width of the request count and error count.
REQ-004 SHALL have parameter TIMEOUT, default 1024, watchdog limit in mclk cycles.
REQ-005 SHALL have port mclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port s_resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that launches a test run.
REQ-008 SHALL have port mode, input, 2 bits: data pattern select; 00=INC, 01=WALK1, 10=ALT, 11=ADDR.
REQ-009 SHALL have ports base_adr (ADDR_W), stride (ADDR_W), num_req (CNT_W) and req_len (2 bits), all inputs: run configuration.
REQ-010 SHALL have port sdc_init_done, input, 1 bit: controller initialisation complete.
REQ-011 SHALL have port sdc_req, output, 1 bit: request to the controller.
REQ-012 SHALL have ports sdc_req_adr (ADDR_W), sdc_req_len (2 bits) and sdc_req_wr_n (1 bit), all outputs: request attributes; sdc_req_wr_n=1 means read.
REQ-013 SHALL have port sdc_req_ack, input, 1 bit: request accepted.
REQ-014 SHALL have ports sdc_wr_data (DATA_W) and sdc_wr_en_n (DATA_W/8), outputs, plus sdc_wr_next, input, 1 bit: write data path.
REQ-015 SHALL have ports sdc_rd_data (DATA_W) and sdc_rd_valid (1 bit), inputs: read data path.
REQ-016 SHALL have status outputs busy (1 bit), done (1 bit), timeout (1 bit), err_cnt (CNT_W) and first_err_adr (ADDR_W).

Function
REQ-017 SHALL implement the FSM states IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA and DONE.
REQ-018 SHALL, in IDLE, accept start only when sdc_init_done=1 and num_req!=0; it latches the configuration, clears status and enters WR_REQ; otherwise start is ignored.
REQ-019 SHALL ignore start in every state other than IDLE and DONE; start in DONE SHALL behave as in IDLE.
REQ-020 SHALL set request address i (0-based) to base_adr + i*stride, computed modulo 2^ADDR_W and wrapping silently.
REQ-021 SHALL, in WR_REQ/RD_REQ, hold sdc_req=1 with stable adr, len and wr_n until sdc_req_ack is sampled 1, and drive sdc_req=0 from the next cycle.
REQ-022 SHALL transfer 4<<req_len data words per request (4, 8, 16 or 32).
REQ-023 SHALL drive word k on sdc_wr_data in WR_DATA and advance to k+1 on each cycle sdc_wr_next=1; after the last word it SHALL go to WR_REQ for the next request, or to RD_REQ with i=0 after num_req writes.
REQ-024 SHALL drive sdc_wr_en_n to all zeros throughout.
REQ-025 SHALL define pattern word g (global word index within the run) as: INC=g; WALK1=1<<(g mod DATA_W); ALT=all-0xA bytes for even g, all-0x5 bytes for odd g; ADDR=the request address zero-extended, plus the word index within the request.
REQ-026 SHALL, in RD_DATA, compare sdc_rd_data against the same pattern on each cycle sdc_rd_valid=1; a mismatch increments err_cnt (saturating at all ones) and, on the first error only, captures that request's address in first_err_adr.
REQ-027 SHALL, after the last read word of the last request, enter DONE; done=1 and busy=0 hold in DONE until start or reset.
REQ-028 SHALL count sdc_rd_valid=1 outside RD_DATA while busy as one error (overrun), with no state change.
REQ-029 SHALL run a watchdog that counts cycles in a REQ or DATA state without ack, wr_next or rd_valid progress; reaching TIMEOUT sets timeout=1, drops sdc_req and enters DONE.
REQ-030 SHALL hold busy=1 in every state except IDLE and DONE.

Reset
REQ-031 SHALL, while s_resetn=0, asynchronously force: state=IDLE; sdc_req=0; sdc_req_adr=0; sdc_req_len=0; sdc_req_wr_n=0; sdc_wr_data=0; busy=0; done=0; timeout=0; err_cnt=0; first_err_adr=0; all counters=0.
REQ-032 SHALL treat reset mid-run as an abort with no completion indication; release returns the block to IDLE.

Verification
REQ-033 SHALL be verified with: base=0x000200, stride=0x20, num_req=2, req_len=1, mode=INC, memory model -> 2 write and 2 read requests at 0x200 and 0x220, 8 words each, done=1, err_cnt=0.
REQ-034 SHALL be verified with: mode=WALK1, DATA_W=32, req_len=3, num_req=2 -> write words 32..63 carry 1<<0..1<<31, err_cnt=0.
REQ-035 SHALL be verified with: read word 5 of request 1 corrupted, base=0x400, stride=0x40 -> err_cnt=1, first_err_adr=0x440.
REQ-036 SHALL be verified with: sdc_req_ack never asserted, TIMEOUT=1024 -> timeout=1 and done=1 after 1024 cycles, sdc_req=0.
REQ-037 SHALL be verified with: start while sdc_init_done=0, then start while busy -> both ignored; base=0x7FFFE0, stride=0x20 -> second address 0x000000.
REQ-038 SHALL be verified with: s_resetn pulsed low during WR_DATA -> all outputs at reset values immediately; the next start begins a clean run.
